switch_debouncer: RTL

Synchronizes and debounces the slide-switch operand bus before it reaches the math block and seven-segment decoder. It sits between the `sw` pins and the `A`/`B` operand inputs in the top level. The raw asynchronous bus is resampled into the `clock` domain, and a new value is published only after it has held steady for a programmable number of cycles. A one-cycle pulse marks every committed change.

---
 rtl/debounce_pkg.sv | 10 +
 rtl/bit_synchronizer.sv | 25 ++
 rtl/switch_debouncer.sv | 78 +++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the switch debouncer: state encoding of the settle FSM.
package debounce_pkg;

  // Committed value is current, or a candidate value is being timed.
  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_SETTLING = 1'b1
  } state_t;

endpackage

// File: rtl/bit_synchronizer.sv
// Parameterized-width two-flop synchronizer, bit-parallel, async active-high reset.
// Intended for any asynchronous board input (slide switches, push buttons).
module bit_synchronizer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync1;

  // First flop may go metastable; second flop gives it a full cycle to resolve.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      q     <= '0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Slide-switch bus debouncer: synchronizes the raw bus, then publishes a new value only
// after it has held unchanged for STABLE_COUNT cycles. The whole bus commits atomically;
// a bounce on any bit restarts the timer for all bits. A one-cycle pulse marks each commit.
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned STABLE_COUNT = 1000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic             changed,
  output logic             settling
);

  // Counter only needs to reach STABLE_COUNT-1; keep at least one bit.
  localparam int unsigned CNT_W = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] candidate;
  logic [CNT_W-1:0] count;
  state_t           state;

  bit_synchronizer #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (raw),
    .q     (sync2)
  );

  // Settle FSM: times a candidate value and commits it once it has held long enough.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_STABLE;
      candidate <= '0;
      count     <= '0;
      stable    <= '0;
      changed   <= 1'b0;
    end else begin
      changed <= 1'b0;
      unique case (state)
        ST_STABLE: begin
          if (sync2 != stable) begin
            candidate <= sync2;
            count     <= '0;
            state     <= ST_SETTLING;
          end
        end
        ST_SETTLING: begin
          if (sync2 == stable) begin
            // Input bounced back to the committed value: drop the candidate silently.
            state <= ST_STABLE;
          end else if (sync2 != candidate) begin
            // A different value appeared: restart timing from it.
            candidate <= sync2;
            count     <= '0;
          end else if (count == CNT_LAST) begin
            stable  <= candidate;
            changed <= 1'b1;
            state   <= ST_STABLE;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: state <= ST_STABLE;
      endcase
    end
  end

  // Decoded straight from the state flop, so no path from raw.
  assign settling = (state == ST_SETTLING);

endmodule
